fetch_stage: RTL and testbench

- Instruction-fetch stage; produces the IF/ID register contents that the decode stage consumes.
- Owns the PC and issues requests to instruction memory over a req/valid handshake.
- Absorbs decode's stall, flush and branch_pc redirect, and stops fetching after a HLT.
- Inserts PCS $0 (16'hE000) bubbles whenever no valid instruction is available.

---
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to imem over req/valid, fills IF/ID.
// Define FETCH_PERF_CNT_EN to add the fetch_count/bubble_count performance counters.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'hE000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] branch_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] curr_pc_fd,
  output logic [15:0] curr_instr_fd,
  output logic        fd_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] bubble_count
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALT} state_t;

  state_t      state, next_state;
  logic [15:0] pc;
  logic [15:0] hold_buf;
  logic [15:0] issued_addr;
  logic        adv;
  logic        load_instr;
  logic        load_nop;
  logic        capture;
  logic        redirect;
  logic [15:0] new_instr;

  assign adv = enable & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  // Flush beats stall/enable in every state; the chosen action drives the datapath below.
  always_comb begin
    next_state = state;
    load_instr = 1'b0;
    load_nop   = 1'b0;
    capture    = 1'b0;
    redirect   = 1'b0;
    new_instr  = imem_rdata;
    case (state)
      FETCH: begin
        if (flush) begin
          redirect   = 1'b1;
          load_nop   = 1'b1;
          next_state = imem_valid ? FETCH : DRAIN;
        end else if (imem_valid && adv) begin
          load_instr = 1'b1;
          next_state = (imem_rdata[15:12] == 4'hF) ? HALT : FETCH;
        end else if (imem_valid) begin
          capture    = 1'b1;
          next_state = HOLD;
        end else if (adv) begin
          load_nop = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          redirect   = 1'b1;
          load_nop   = 1'b1;
          next_state = FETCH;
        end else if (adv) begin
          load_instr = 1'b1;
          new_instr  = hold_buf;
          next_state = (hold_buf[15:12] == 4'hF) ? HALT : FETCH;
        end
      end
      DRAIN: begin
        if (flush) begin
          redirect = 1'b1;
          load_nop = 1'b1;
        end else if (adv) begin
          load_nop = 1'b1;
        end
        if (imem_valid) next_state = FETCH;
      end
      HALT: begin
        if (flush) begin
          redirect   = 1'b1;
          load_nop   = 1'b1;
          next_state = FETCH;
        end else if (adv) begin
          load_nop = 1'b1;
        end
      end
      default: next_state = FETCH;
    endcase
  end

  // DRAIN keeps presenting the address of the request that is still in flight.
  always_comb begin
    imem_req  = (state == FETCH) || (state == DRAIN);
    imem_addr = (state == DRAIN) ? issued_addr : pc;
    halted    = (state == HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      hold_buf      <= 16'h0000;
      issued_addr   <= RESET_PC;
      curr_instr_fd <= NOP_INSTR;
      curr_pc_fd    <= 16'h0000;
      fd_valid      <= 1'b0;
    end else begin
      if (state == FETCH) issued_addr <= pc;
      if (capture) hold_buf <= imem_rdata;
      if (redirect) pc <= branch_pc;
      else if (load_instr) pc <= pc + 16'd2;
      if (load_instr) begin
        curr_instr_fd <= new_instr;
        curr_pc_fd    <= pc + 16'd2;
        fd_valid      <= 1'b1;
      end else if (load_nop) begin
        curr_instr_fd <= NOP_INSTR;
        fd_valid      <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count  <= 16'h0000;
      bubble_count <= 16'h0000;
    end else begin
      if (load_instr && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      if (load_nop && adv && bubble_count != 16'hFFFF) bubble_count <= bubble_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: tests push expected IF/ID loads,
// a monitor pops and compares whenever the stage advances with fd_valid=1.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        stall;
  logic        flush;
  logic [15:0] branch_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] curr_pc_fd;
  logic [15:0] curr_instr_fd;
  logic        fd_valid;
  logic        halted;

  logic        mem_on;
  int          latency;
  int          wait_cnt;
  logic [15:0] hlt_addr;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'hE000)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .stall(stall), .flush(flush),
    .branch_pc(branch_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .curr_pc_fd(curr_pc_fd),
    .curr_instr_fd(curr_instr_fd), .fd_valid(fd_valid), .halted(halted)
  );

  // Memory model: word at address A is 16'h1000 | A/2, with an optional HLT slot.
  assign imem_valid = mem_on && imem_req && (wait_cnt >= latency);
  assign imem_rdata = (imem_addr == hlt_addr) ? 16'hF000 : (16'h1000 | {1'b0, imem_addr[15:1]});

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (!imem_req || imem_valid || !mem_on) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExpected(input logic [15:0] instr, input logic [15:0] pc);
    sb_q.push_back('{instr: instr, pc: pc});
  endtask

  task automatic applyStimulus(input logic n_stall, input logic n_flush,
                               input logic [15:0] n_br, input logic n_mem);
    stall     = n_stall;
    flush     = n_flush;
    branch_pc = n_br;
    mem_on    = n_mem;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset(input int lat);
    @(negedge clk);
    rst_n    = 1'b0;
    enable   = 1'b1;
    latency  = lat;
    hlt_addr = 16'h0001;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    tick(2);
  endtask

  // Monitor: an edge with adv=1 loads IF/ID; a real instruction must match the queue head.
  initial begin
    logic loaded;
    exp_t e;
    forever begin
      @(posedge clk);
      loaded = rst_n && enable && !stall;
      #1;
      if (loaded && fd_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL sb_unexpected: got %h@%h, expected nothing", curr_instr_fd, curr_pc_fd);
        end else begin
          e = sb_q.pop_front();
          checkOutput("sb_instr", curr_instr_fd, e.instr);
          checkOutput("sb_pc", curr_pc_fd, e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    latency = 0;
    hlt_addr = 16'h0001;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);

    // Reset values
    tick(2);
    checkOutput("rst_fd_valid", {15'd0, fd_valid}, 16'd0);
    checkOutput("rst_instr", curr_instr_fd, 16'hE000);
    checkOutput("rst_pc_fd", curr_pc_fd, 16'h0000);
    checkOutput("rst_halted", {15'd0, halted}, 16'd0);
    checkOutput("rst_addr", imem_addr, 16'h0000);
    checkOutput("rst_req", {15'd0, imem_req}, 16'd1);

    // Zero-latency streaming
    doReset(0);
    pushExpected(16'h1000, 16'h0002);
    pushExpected(16'h1001, 16'h0004);
    pushExpected(16'h1002, 16'h0006);
    rst_n = 1'b1; mem_on = 1'b1;
    tick(3);
    checkOutput("z_addr", imem_addr, 16'h0006);
    checkOutput("z_instr", curr_instr_fd, 16'h1002);
    mem_on = 1'b0;

    // Two-cycle latency: bubbles between instructions
    doReset(2);
    pushExpected(16'h1000, 16'h0002);
    pushExpected(16'h1001, 16'h0004);
    rst_n = 1'b1; mem_on = 1'b1;
    tick(1);
    checkOutput("l_bubble0", {15'd0, fd_valid}, 16'd0);
    tick(3);
    checkOutput("l_bubble_valid", {15'd0, fd_valid}, 16'd0);
    checkOutput("l_bubble_instr", curr_instr_fd, 16'hE000);
    checkOutput("l_addr_hold1", imem_addr, 16'h0002);
    tick(1);
    checkOutput("l_addr_hold2", imem_addr, 16'h0002);
    checkOutput("l_req_hold", {15'd0, imem_req}, 16'd1);
    tick(1);
    mem_on = 1'b0;

    // Stall (and one enable=0 cycle) while a response arrives
    doReset(0);
    pushExpected(16'h1000, 16'h0002);
    pushExpected(16'h1001, 16'h0004);
    pushExpected(16'h1002, 16'h0006);
    rst_n = 1'b1; mem_on = 1'b1;
    tick(1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    tick(1);
    checkOutput("s_req", {15'd0, imem_req}, 16'd0);
    checkOutput("s_instr", curr_instr_fd, 16'h1000);
    stall = 1'b0; enable = 1'b0;
    tick(1);
    checkOutput("s_en_instr", curr_instr_fd, 16'h1000);
    checkOutput("s_en_pc", curr_pc_fd, 16'h0002);
    stall = 1'b1; enable = 1'b1;
    tick(1);
    checkOutput("s_req3", {15'd0, imem_req}, 16'd0);
    checkOutput("s_valid3", {15'd0, fd_valid}, 16'd1);
    stall = 1'b0;
    tick(1);
    checkOutput("s_release_instr", curr_instr_fd, 16'h1001);
    checkOutput("s_release_pc", curr_pc_fd, 16'h0004);
    tick(1);
    mem_on = 1'b0;

    // Flush with a request to 0x0008 outstanding
    doReset(0);
    pushExpected(16'h1000, 16'h0002);
    pushExpected(16'h1001, 16'h0004);
    pushExpected(16'h1002, 16'h0006);
    pushExpected(16'h1003, 16'h0008);
    pushExpected(16'h1020, 16'h0042);
    rst_n = 1'b1; mem_on = 1'b1;
    tick(4);
    checkOutput("f_pre_addr", imem_addr, 16'h0008);
    applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0);
    tick(1);
    checkOutput("f_nop_valid", {15'd0, fd_valid}, 16'd0);
    checkOutput("f_nop_instr", curr_instr_fd, 16'hE000);
    checkOutput("f_drain_addr", imem_addr, 16'h0008);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    tick(1);
    checkOutput("f_new_addr", imem_addr, 16'h0040);
    checkOutput("f_stale_valid", {15'd0, fd_valid}, 16'd0);
    tick(1);
    mem_on = 1'b0;

    // HLT at 0x000A, then redirect to 0x0020
    doReset(0);
    hlt_addr = 16'h000A;
    pushExpected(16'h1000, 16'h0002);
    pushExpected(16'h1001, 16'h0004);
    pushExpected(16'h1002, 16'h0006);
    pushExpected(16'h1003, 16'h0008);
    pushExpected(16'h1004, 16'h000A);
    pushExpected(16'hF000, 16'h000C);
    pushExpected(16'h1010, 16'h0022);
    rst_n = 1'b1; mem_on = 1'b1;
    tick(6);
    checkOutput("h_halted", {15'd0, halted}, 16'd1);
    checkOutput("h_req", {15'd0, imem_req}, 16'd0);
    tick(1);
    checkOutput("h_nop", curr_instr_fd, 16'hE000);
    checkOutput("h_halted2", {15'd0, halted}, 16'd1);
    applyStimulus(1'b0, 1'b1, 16'h0020, 1'b1);
    tick(1);
    checkOutput("h_unhalt", {15'd0, halted}, 16'd0);
    checkOutput("h_resume_addr", imem_addr, 16'h0020);
    checkOutput("h_resume_req", {15'd0, imem_req}, 16'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    tick(1);
    mem_on = 1'b0;
    hlt_addr = 16'h0001;

    // Asynchronous reset in the middle of DRAIN
    doReset(0);
    pushExpected(16'h1000, 16'h0002);
    pushExpected(16'h1000, 16'h0002);
    rst_n = 1'b1; mem_on = 1'b1;
    tick(1);
    applyStimulus(1'b0, 1'b1, 16'h0080, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("r_drain_addr", imem_addr, 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("r_addr", imem_addr, 16'h0000);
    checkOutput("r_pc_fd", curr_pc_fd, 16'h0000);
    checkOutput("r_valid", {15'd0, fd_valid}, 16'd0);
    checkOutput("r_instr", curr_instr_fd, 16'hE000);
    tick(1);
    rst_n = 1'b1; mem_on = 1'b1;
    tick(1);
    mem_on = 1'b0;

    tick(3);
    checkOutput("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
